// File: rtl/sync_fifo_ext_if.sv
// sync_fifo_ext_if: push/pop, control and status bundle between a FIFO and its producer/consumer
interface sync_fifo_ext_if #(
  parameter int WIDTH = 16,
  parameter int AW = 3
);
  logic wr_en, rd_en, flush, clr_err;
  logic [WIDTH-1:0] data_in, data_out;
  logic valid, empty, full, almost_full, almost_empty, overflow, underflow;
  logic [AW:0] count;
  modport master (
    output wr_en, data_in, rd_en, flush, clr_err,
    input data_out, valid, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
  modport slave (
    input wr_en, data_in, rd_en, flush, clr_err,
    output data_out, valid, empty, full, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// sync_fifo_ext: single-clock FIFO with selectable read mode, fill thresholds, flush and sticky errors
module sync_fifo_ext #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH),
  parameter int AFULL_TH = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter bit FWFT = 1'b0
) (
  input logic clk,
  input logic rst_n,
  sync_fifo_ext_if.slave f
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic empty, full, rd_acc, wr_acc, do_rd, do_wr;
  logic ovf_q, ovf_d, unf_q, unf_d;
  logic [WIDTH-1:0] head;
  assign count = wr_ptr_q - rd_ptr_q;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign rd_acc = f.rd_en & ~empty;
  assign wr_acc = f.wr_en & (~full | rd_acc);
  assign do_rd = rd_acc & ~f.flush;
  assign do_wr = wr_acc & ~f.flush;
  assign head = mem_q[rd_ptr_q[AW-1:0]];
  assign f.count = count;
  assign f.empty = empty;
  assign f.full = full;
  assign f.almost_full = count >= (AW+1)'(AFULL_TH);
  assign f.almost_empty = count <= (AW+1)'(AEMPTY_TH);
  assign f.overflow = ovf_q;
  assign f.underflow = unf_q;
  // pointer advance with flush priority; error flags are sticky and a new set beats clr_err
  always_comb begin
    wr_ptr_d = f.flush ? '0 : wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = f.flush ? '0 : rd_ptr_q + (AW+1)'(do_rd);
    ovf_d = (ovf_q & ~f.clr_err) | (f.wr_en & ~wr_acc & ~f.flush);
    unf_d = (unf_q & ~f.clr_err) | (f.rd_en & empty & ~f.flush);
  end
  // pointer and error-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  // storage is never reset; the empty gate keeps stale words invisible
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= f.data_in;
  end
  if (FWFT) begin : g_fwft
    assign f.data_out = empty ? '0 : head;
    assign f.valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] dout_q, dout_d;
    logic valid_q, valid_d;
    // registered read: capture the head on an accepted pop, clear on flush, else hold
    always_comb begin
      dout_d = f.flush ? '0 : do_rd ? head : dout_q;
      valid_d = do_rd;
    end
    // read-data register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        valid_q <= 1'b0;
      end else begin
        dout_q <= dout_d;
        valid_q <= valid_d;
      end
    end
    assign f.data_out = dout_q;
    assign f.valid = valid_q;
  end
endmodule
